mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_rr.sv | 17 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a tie goes to whoever was not granted last.
module mem_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    always_comb begin
        if (req0 && req1) begin
            winner = ~last;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port memory; one access in flight at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    state_t           state_reg;
    logic             last_reg;
    logic             winner_reg;
    logic             we_reg;
    logic             gnt0_reg;
    logic             gnt1_reg;
    logic             rvalid0_reg;
    logic             rvalid1_reg;
    logic             mem_we_reg;
    logic [WIDTH-1:0] mem_a_reg;
    logic [WIDTH-1:0] mem_wd_reg;
    logic             winner;

    mem_arb_rr u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (last_reg),
        .winner (winner)
    );

    // Pulses default low each cycle; address/data registers hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            winner_reg  <= 1'b0;
            we_reg      <= 1'b0;
            gnt0_reg    <= 1'b0;
            gnt1_reg    <= 1'b0;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            mem_a_reg   <= '0;
            mem_wd_reg  <= '0;
        end else begin
            gnt0_reg    <= 1'b0;
            gnt1_reg    <= 1'b0;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_reg  <= ACCESS;
                        winner_reg <= winner;
                        last_reg   <= winner;
                        we_reg     <= winner ? we1 : we0;
                        mem_we_reg <= winner ? we1 : we0;
                        mem_a_reg  <= winner ? addr1 : addr0;
                        mem_wd_reg <= winner ? wdata1 : wdata0;
                        gnt0_reg   <= ~winner;
                        gnt1_reg   <= winner;
                    end
                end
                ACCESS: begin
                    if (we_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        state_reg   <= RESP;
                        rvalid0_reg <= ~winner_reg;
                        rvalid1_reg <= winner_reg;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_reg;
    assign gnt1    = gnt1_reg;
    assign rvalid0 = rvalid0_reg;
    assign rvalid1 = rvalid1_reg;
    assign mem_we  = mem_we_reg;
    assign mem_a   = mem_a_reg;
    assign mem_wd  = mem_wd_reg;

    // Memory read data is live during RESP; only the selected requester sees it.
    assign rdata0 = rvalid0_reg ? mem_rd : '0;
    assign rdata1 = rvalid1_reg ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic         gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [W-1:0] rdata0, rdata1, mem_a, mem_wd;
    logic [W-1:0] mem_rd = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Synchronous single-port memory: read data follows the address by one cycle.
    logic [W-1:0] dmem [0:255];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_a[7:0]] <= mem_wd;
        mem_rd <= dmem[mem_a[7:0]];
    end

    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: transaction-level view of the arbiter.
    logic [W-1:0] ref_mem [0:255];
    int           m_busy;
    bit           m_last;
    bit           m_resp;
    bit           m_rdwho;
    logic [W-1:0] m_rdaddr;
    bit           m_pw;
    logic [W-1:0] m_pwaddr, m_pwdata;
    logic [W-1:0] exp_a, exp_wd;

    int           gnt_who[$];
    int           gnt_cyc[$];
    logic [W-1:0] last_rd1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 1'b1; m_resp = 1'b0; m_pw = 1'b0;
        exp_a = '0; exp_wd = '0;
    endtask

    task automatic drive_inputs();
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (req0) {we0, addr0, wdata0} = q0[0];
        else      {we0, addr0, wdata0} = {1'($urandom), W'($urandom), W'($urandom)};
        if (req1) {we1, addr1, wdata1} = q1[0];
        else      {we1, addr1, wdata1} = {1'($urandom), W'($urandom), W'($urandom)};
    endtask

    task automatic step();
        bit           r0, r1, w;
        txn_t         t;
        bit           e_g0, e_g1, e_rv0, e_rv1, e_we;
        logic [W-1:0] e_rd0, e_rd1;
        t = '0;
        @(posedge clk);
        cyc++;
        r0 = req0; r1 = req1;
        e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_rd0 = '0; e_rd1 = '0;
        if (m_pw) begin
            ref_mem[m_pwaddr[7:0]] = m_pwdata;
            m_pw = 1'b0;
        end
        if (m_resp) begin
            if (m_rdwho) begin e_rv1 = 1; e_rd1 = ref_mem[m_rdaddr[7:0]]; end
            else         begin e_rv0 = 1; e_rd0 = ref_mem[m_rdaddr[7:0]]; end
            m_resp = 1'b0;
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (r0 || r1) begin
            w = (r0 && r1) ? !m_last : r1;
            m_last = w;
            t = w ? txn_t'{we1, addr1, wdata1} : txn_t'{we0, addr0, wdata0};
            if (w) e_g1 = 1; else e_g0 = 1;
            e_we = t.we;
            exp_a = t.addr;
            exp_wd = t.wdata;
            if (t.we) begin
                m_pw = 1'b1; m_pwaddr = t.addr; m_pwdata = t.wdata; m_busy = 1;
            end else begin
                m_resp = 1'b1; m_rdwho = w; m_rdaddr = t.addr; m_busy = 2;
            end
        end
        #1;
        check("gnt0", gnt0, e_g0);
        check("gnt1", gnt1, e_g1);
        check("rvalid0", rvalid0, e_rv0);
        check("rvalid1", rvalid1, e_rv1);
        check("rdata0", rdata0, e_rd0);
        check("rdata1", rdata1, e_rd1);
        check("mem_we", mem_we, e_we);
        check("mem_a", mem_a, exp_a);
        check("mem_wd", mem_wd, exp_wd);
        if (gnt0) begin gnt_who.push_back(0); gnt_cyc.push_back(cyc); end
        if (gnt1) begin gnt_who.push_back(1); gnt_cyc.push_back(cyc); end
        if (rvalid1) last_rd1 = rdata1;
        if (gnt0 && q0.size() > 0) void'(q0.pop_front());
        if (gnt1 && q1.size() > 0) void'(q1.pop_front());
        drive_inputs();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy > 0 || m_resp) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_left", q0.size() + q1.size(), 0);
    endtask

    // Asserts reset off-edge, checks outputs clear immediately, then releases on a falling edge.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_gnt"}, {gnt1, gnt0}, 0);
        check({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
        check({tag, "_mem_a"}, mem_a, 0);
        check({tag, "_mem_wd"}, mem_wd, 0);
        check({tag, "_rdata"}, rdata0 | rdata1, 0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold_mem_we"}, mem_we, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        bit alt_ok;
        for (int i = 0; i < 256; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
        model_reset();
        drive_inputs();
        #2;
        apply_reset("reset");

        // Quiet bus
        repeat (10) step();

        // Write then read back from the other requester
        q0.push_back(txn_t'{1'b1, W'(17), W'('h25)});
        drive_inputs();
        drain(20);
        q1.push_back(txn_t'{1'b0, W'(17), W'(0)});
        drive_inputs();
        last_rd1 = '0;
        drain(20);
        check("rd17_data", last_rd1, W'('h25));

        // Continuous contention after a fresh reset: grants alternate, 3 cycles apart
        @(negedge clk);
        apply_reset("reset2");
        gnt_who.delete(); gnt_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(txn_t'{1'b0, W'(7), W'($urandom)});
            q1.push_back(txn_t'{1'b0, W'(17), W'($urandom)});
        end
        drive_inputs();
        drain(60);
        check("alt_count", gnt_who.size(), 8);
        alt_ok = 1;
        for (int i = 0; i < gnt_who.size(); i++) if (gnt_who[i] != (i % 2)) alt_ok = 0;
        for (int i = 1; i < gnt_cyc.size(); i++) if (gnt_cyc[i] - gnt_cyc[i-1] != 3) alt_ok = 0;
        check("alt_order_spacing", alt_ok, 1);

        // Request raised during RESP waits for the next idle cycle
        gnt_who.delete(); gnt_cyc.delete();
        q0.push_back(txn_t'{1'b0, W'(7), W'(0)});
        drive_inputs();
        step();
        step();
        check("resp_state_rvalid0", rvalid0, 1);
        base = cyc;
        q1.push_back(txn_t'{1'b0, W'(17), W'(0)});
        drive_inputs();
        drain(20);
        check("late_gnt_count", gnt_who.size(), 2);
        if (gnt_cyc.size() == 2) check("late_gnt1_delay", gnt_cyc[1] - base, 2);

        // Reset mid-ACCESS of a write: aborted, and the pending request is granted afresh
        gnt_who.delete(); gnt_cyc.delete();
        q0.push_back(txn_t'{1'b1, W'(3), W'('hAA)});
        q0.push_back(txn_t'{1'b1, W'(4), W'('hBB)});
        drive_inputs();
        step();
        check("abort_mem_we_before", mem_we, 1);
        #2;
        apply_reset("abort");
        step();
        check("abort_regrant", gnt0, 1);
        drain(20);
        q1.push_back(txn_t'{1'b0, W'(3), W'(0)});
        q1.push_back(txn_t'{1'b0, W'(4), W'(0)});
        drive_inputs();
        drain(20);
        check("abort_rd4", last_rd1, W'('hBB));

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(2) == 0)
                q0.push_back(txn_t'{1'($urandom), W'($urandom_range(15)), W'($urandom)});
            if (q1.size() == 0 && $urandom_range(2) == 0)
                q1.push_back(txn_t'{1'($urandom), W'($urandom_range(15)), W'($urandom)});
            drive_inputs();
            step();
        end
        drain(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
